// File: rtl/imem_sync_fetch.sv
// Writable synchronous instruction memory: zero-clear sweep after reset, program port,
// 1-cycle valid/ready fetch with backpressure and flush. Optional parity: IMEM_PARITY_EN.
module imem_sync_fetch #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_err,
    input  logic              flush,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              init_done
`ifdef IMEM_PARITY_EN
    ,
    input  logic              prog_par_inv
`endif
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state;
    logic [IDX_W-1:0]  clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  req_idx, prog_idx;
    logic              req_mis, req_oor, prog_oor, accept;
    logic              unused_prog;

    assign req_idx  = req_addr[IDX_W+1:2];
    assign prog_idx = prog_addr[IDX_W+1:2];
    assign req_mis  = |req_addr[1:0];
    assign req_oor  = |(req_addr >> (IDX_W + 2));
    assign prog_oor = |(prog_addr >> (IDX_W + 2));
    assign unused_prog = &{1'b0, prog_addr[1:0]};

    // Program writes win over fetches, so a read never collides with a write.
    assign req_ready = (state == RUN) && !prog_we && !flush && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;

`ifdef IMEM_PARITY_EN
    logic mem_par [DEPTH];
    logic rd_par_err;

    assign rd_par_err = (^mem[req_idx]) != mem_par[req_idx];

    always_ff @(posedge clk) begin
        if (state == CLEAR)
            mem_par[clr_cnt] <= 1'b0;
        else if (prog_we && !prog_oor)
            mem_par[prog_idx] <= (^prog_data) ^ prog_par_inv;
    end
`endif

    // Array has no reset; the CLEAR sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            mem[clr_cnt] <= '0;
        else if (prog_we && !prog_oor)
            mem[prog_idx] <= prog_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            init_done <= 1'b0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == IDX_W'(DEPTH - 1)) begin
                state     <= RUN;
                init_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 2'b00;
        end else if (flush) begin
            rsp_valid <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            if (req_mis) begin
                rsp_data <= '0;
                rsp_err  <= 2'b01;
            end else if (req_oor) begin
                rsp_data <= '0;
                rsp_err  <= 2'b10;
`ifdef IMEM_PARITY_EN
            end else if (rd_par_err) begin
                rsp_data <= '0;
                rsp_err  <= 2'b11;
`endif
            end else begin
                rsp_data <= mem[req_idx];
                rsp_err  <= 2'b00;
            end
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_imem_sync_fetch.sv
// Directed bench for imem_sync_fetch: clear sweep, program/fetch, errors,
// pipelining, backpressure, flush, write priority and mid-run reset.
module tb_imem_sync_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, flush, prog_we, init_done;
    logic [31:0] req_addr, prog_addr, prog_data, rsp_data;
    logic [1:0]  rsp_err;
`ifdef IMEM_PARITY_EN
    logic        prog_par_inv;
`endif
    logic [31:0] model [64];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    imem_sync_fetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .flush(flush), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .init_done(init_done)
`ifdef IMEM_PARITY_EN
        , .prog_par_inv(prog_par_inv)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Waits for the sweep from the current negedge; expects exactly 64 cycles.
    task automatic wait_init();
        int n = 0;
        int seen_ready = 0;
        while (n < 200) begin
            @(posedge clk); #1;
            n++;
            if (init_done) break;
            if (req_ready) seen_ready = 1;
        end
        chk("init_cycles", 64'(n), 64'd64);
        chk("ready_during_clear", 64'(seen_ready), 64'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(posedge clk); #1;
        prog_we = 1'b0;
        if (a < 32'h100) model[a[7:2]] = d;
    endtask

    task automatic fetch(input string tag, input logic [31:0] a,
                         input logic [31:0] ed, input logic [1:0] ee);
        @(negedge clk);
        req_valid = 1'b1; req_addr = a;
        #1 chk({tag, "_rdy"}, req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({tag, "_vld"}, rsp_valid, 1'b1);
        chk({tag, "_data"}, rsp_data, ed);
        chk({tag, "_err"}, rsp_err, ee);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1; flush = 1'b0;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;
`ifdef IMEM_PARITY_EN
        prog_par_inv = 1'b0;
`endif
        for (int i = 0; i < 64; i++) model[i] = '0;
        #12;
        chk("rst_vld", rsp_valid, 1'b0);
        chk("rst_data", rsp_data, 32'h0);
        chk("rst_err", rsp_err, 2'b00);
        chk("rst_init", init_done, 1'b0);
        chk("rst_ready", req_ready, 1'b0);

        // Writes during the sweep must be ignored.
        @(negedge clk);
        rst_n = 1'b1;
        prog_we = 1'b1; prog_addr = 32'h10; prog_data = 32'hdead_beef;
        wait_init();
        prog_we = 1'b0;
        fetch("post_clear", 32'h10, 32'h0, 2'b00);

        wr(32'h0, 32'h2000_0003);
        fetch("rd_after_wr", 32'h0, 32'h2000_0003, 2'b00);
        fetch("misalign", 32'h6, 32'h0, 2'b01);
        fetch("oor", 32'h100, 32'h0, 2'b10);
        fetch("mis_over_oor", 32'h103, 32'h0, 2'b01);
        fetch("oor_high", 32'h8000_0000, 32'h0, 2'b10);

        wr(32'h100, 32'hbad0_bad0);
        for (int i = 0; i < 64; i++) begin
            logic [31:0] a;
            a = 32'(i) << 2;
            fetch($sformatf("scan%0d", i), a, model[i], 2'b00);
        end

        wr(32'h4, 32'h1111_1111);
        wr(32'h8, 32'h2222_2222);

        // Back-to-back: one response per cycle.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0;
        @(posedge clk); #1;
        chk("b2b0_vld", rsp_valid, 1'b1);
        chk("b2b0_data", rsp_data, 32'h2000_0003);
        req_addr = 32'h4;
        chk("b2b_rdy", req_ready, 1'b1);
        @(posedge clk); #1;
        chk("b2b1_data", rsp_data, 32'h1111_1111);
        req_addr = 32'h8;
        @(posedge clk); #1;
        chk("b2b2_vld", rsp_valid, 1'b1);
        chk("b2b2_data", rsp_data, 32'h2222_2222);
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b_drain", rsp_valid, 1'b0);

        // Backpressure: response held, no new accept.
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h4;
        @(posedge clk); #1;
        req_addr = 32'h8;
        for (int i = 0; i < 3; i++) begin
            chk("hold_rdy", req_ready, 1'b0);
            chk("hold_vld", rsp_valid, 1'b1);
            chk("hold_data", rsp_data, 32'h1111_1111);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1 chk("release_rdy", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("release_data", rsp_data, 32'h2222_2222);
        @(posedge clk); #1;
        chk("release_drain", rsp_valid, 1'b0);

        // Flush drops a held response and blocks acceptance.
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
        @(posedge clk); #1;
        chk("pre_flush_vld", rsp_valid, 1'b1);
        flush = 1'b1; req_addr = 32'h4;
        #1 chk("flush_rdy", req_ready, 1'b0);
        @(posedge clk); #1;
        chk("flush_vld", rsp_valid, 1'b0);
        flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_flush_vld", rsp_valid, 1'b0);

        // Write and fetch in the same cycle: write wins, fetch follows.
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 32'hc; prog_data = 32'h3333_3333;
        req_valid = 1'b1; req_addr = 32'hc;
        #1 chk("we_blocks_rdy", req_ready, 1'b0);
        @(posedge clk); #1;
        chk("we_no_rsp", rsp_valid, 1'b0);
        prog_we = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("we_then_rd_vld", rsp_valid, 1'b1);
        chk("we_then_rd_data", rsp_data, 32'h3333_3333);

`ifdef IMEM_PARITY_EN
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 32'h8; prog_data = 32'hffff_ffff; prog_par_inv = 1'b1;
        @(posedge clk); #1;
        prog_we = 1'b0; prog_par_inv = 1'b0;
        fetch("par_bad", 32'h8, 32'h0, 2'b11);
        wr(32'h8, 32'hffff_ffff);
        fetch("par_ok", 32'h8, 32'hffff_ffff, 2'b00);
`endif

        // Mid-run reset drops the held response at once and re-clears memory.
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("pre_rst_vld", rsp_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_vld", rsp_valid, 1'b0);
        chk("async_rst_init", init_done, 1'b0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_init();
        fetch("rerun_w0", 32'h0, 32'h0, 2'b00);
        fetch("rerun_w3", 32'hc, 32'h0, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
